ccip_c0_rd_arbiter: RTL

Round-robin arbiter that shares the single CCI-P c0 Tx read-request channel of the MPF `afu` interface among N_REQ independent read engines. It tags each request's mdata with the requester index and routes c0 Rx read responses back to the owning requester. It honours c0TxAlmFull, caps outstanding reads per requester, and supports a drain handshake for quiescing before soft-reset or reconfiguration. It sits between the user AFU read engines and the MPF `afu` c0 channels, in the afu_clk domain.

---
 rtl/ccip_c0_rd_arbiter_pkg.sv | 22 ++
 rtl/ccip_c0_rd_arbiter_if.sv | 44 ++++
 rtl/ccip_c0_rd_arbiter_rr.sv | 40 ++++
 rtl/ccip_c0_rd_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ccip_c0_rd_arbiter_pkg.sv
// Shared types and helpers for the c0 read-request arbiter.
package ccip_rd_arb_pkg;

   localparam int MDATA_W_DEF = 16;
   localparam int ADDR_W_DEF  = 42;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } t_arb_state;

   // Requester index lives in the top idx_w bits of the mdata field.
   function automatic int unsigned tag_idx(input logic [31:0] mdata,
                                           input int          mdata_w,
                                           input int          idx_w);
      logic [31:0] mask;
      mask = (32'd1 << idx_w) - 32'd1;
      return (mdata >> (mdata_w - idx_w)) & mask;
   endfunction

endpackage

// File: rtl/ccip_c0_rd_arbiter_if.sv
// Requester, CCI-P c0 Tx/Rx and drain signals of the c0 read arbiter.
interface ccip_c0_rd_arbiter_if
   import ccip_rd_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int MDATA_W = MDATA_W_DEF,
   parameter int DATA_W  = 512
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int UMD_W = MDATA_W - IDX_W;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*UMD_W-1:0]  req_mdata;
   logic [N_REQ-1:0]        req_ready;
   logic                    c0tx_valid;
   logic [ADDR_W-1:0]       c0tx_addr;
   logic [MDATA_W-1:0]      c0tx_mdata;
   logic                    c0_almfull;
   logic                    c0rx_valid;
   logic [MDATA_W-1:0]      c0rx_mdata;
   logic [DATA_W-1:0]       c0rx_data;
   logic [N_REQ-1:0]        rsp_valid;
   logic [UMD_W-1:0]        rsp_mdata;
   logic [DATA_W-1:0]       rsp_data;
   logic                    drain_req;
   logic                    drained;

   modport slave (
      input  req_valid, req_addr, req_mdata, c0_almfull,
             c0rx_valid, c0rx_mdata, c0rx_data, drain_req,
      output req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
             rsp_valid, rsp_mdata, rsp_data, drained
   );

   modport master (
      output req_valid, req_addr, req_mdata, c0_almfull,
             c0rx_valid, c0rx_mdata, c0rx_data, drain_req,
      input  req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
             rsp_valid, rsp_mdata, rsp_data, drained
   );

endinterface

// File: rtl/ccip_c0_rd_arbiter_rr.sv
// N-way round-robin picker; search starts at ptr, ptr moves past each winner.
module ccip_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] ptr;
   int               cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Shares the CCI-P c0 read-request channel among N_REQ read engines and
// routes c0 read responses back by the requester index carried in mdata.
//
// state   | meaning
// RUN     | granting requests to eligible requesters
// DRAIN   | no new grants, waiting for outstanding reads to return
// DRAINED | quiescent; drained=1 until drain_req drops
module ccip_c0_rd_arbiter
   import ccip_rd_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MDATA_W   = MDATA_W_DEF,
   parameter int MAX_OUTST = 64,
   parameter int DATA_W    = 512
) (
   input logic                clk,
   input logic                reset,
   ccip_c0_rd_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int UMD_W = MDATA_W - IDX_W;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   t_arb_state        state, state_nxt;
   logic [CNT_W-1:0]  outst [N_REQ];
   logic [N_REQ-1:0]  elig, grant, rsp_hit;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_any;
   logic              run_ok, all_idle, rx_ok;
   int unsigned       rx_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [UMD_W-1:0]  sel_mdata;

   // almfull gates grants combinationally so requests stop the cycle it rises.
   assign run_ok = !reset && !bus.c0_almfull && (state == RUN);

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = bus.req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST)) && run_ok;
      end
   end

   ccip_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (elig),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign bus.req_ready = grant;

   always_comb begin
      sel_addr  = bus.req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
      sel_mdata = bus.req_mdata[int'(grant_idx) * UMD_W +: UMD_W];
   end

   assign rx_idx = tag_idx(32'(bus.c0rx_mdata), MDATA_W, IDX_W);
   assign rx_ok  = rx_idx < unsigned'(N_REQ);

   always_comb begin
      rsp_hit  = '0;
      all_idle = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_hit[i] = bus.c0rx_valid && rx_ok && (rx_idx == unsigned'(i));
         if (outst[i] != '0) all_idle = 1'b0;
      end
   end

   // Grant and response to the same requester cancel; underflow saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i] && !rsp_hit[i]) begin
               outst[i] <= outst[i] + CNT_W'(1);
            end else if (rsp_hit[i] && !grant[i] && outst[i] != '0) begin
               outst[i] <= outst[i] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.c0tx_valid <= 1'b0;
         bus.c0tx_addr  <= '0;
         bus.c0tx_mdata <= '0;
         bus.rsp_valid  <= '0;
         bus.rsp_mdata  <= '0;
         bus.rsp_data   <= '0;
      end else begin
         bus.c0tx_valid <= grant_any;
         if (grant_any) begin
            bus.c0tx_addr  <= sel_addr;
            bus.c0tx_mdata <= {grant_idx, sel_mdata};
         end
         bus.rsp_valid <= rsp_hit;
         if (bus.c0rx_valid && rx_ok) begin
            bus.rsp_mdata <= bus.c0rx_mdata[UMD_W-1:0];
            bus.rsp_data  <= bus.c0rx_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         bus.drained <= 1'b0;
      end else begin
         state       <= state_nxt;
         bus.drained <= (state_nxt == DRAINED);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (bus.drain_req) state_nxt = DRAIN;
         DRAIN: begin
            if (!bus.drain_req)                     state_nxt = RUN;
            else if (all_idle && !bus.c0tx_valid)   state_nxt = DRAINED;
         end
         DRAINED: if (!bus.drain_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && bus.c0rx_valid) begin
         assert (rx_ok) else $error("c0rx tag %0d has no requester", rx_idx);
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!reset && rsp_hit[i] && !grant[i]) begin
            assert (outst[i] != '0) else $error("response to idle requester %0d", i);
         end
      end
   end

endmodule
